// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Optional response timeout is enabled with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int BE_W        = DATA_W_DFLT / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Owner selection: data first, fetch wins once the data streak
// hits its cap; a lone fetch under flush does not start.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 3
) (
  input  logic          dm_req,
  input  logic          if_req,
  input  logic          flush,
  input  logic [SW-1:0] streak,
  output logic          start,
  output owner_t        owner
);

  logic starve;

  always_comb begin
    starve = dm_req & if_req & (streak == SW'(STARVE_MAX));
    start  = dm_req | (if_req & ~flush);
    owner  = (dm_req & ~starve) ? DATA : FETCH;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data accesses.
// Define MEM_ARB_TIMEOUT_EN to abort RESP after TIMEOUT cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                flush,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_eqmem,
  output logic                stall_mem,
  output logic                timeout_err
);

  localparam int BW = DATA_W / 8;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            sel_owner;
  logic [SW-1:0]     streak_q, streak_d;
  logic              fpend_q, fpend_d;
  logic              we_q, we_d;
  logic [BW-1:0]     be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              start;
  logic              in_req, in_resp, own_dm, rsp, tmo;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX),
    .SW        (SW)
  ) u_prio (
    .dm_req(dm_req),
    .if_req(if_req),
    .flush (flush),
    .streak(streak_q),
    .start (start),
    .owner (sel_owner)
  );

  assign in_req  = (state_q == REQ);
  assign in_resp = (state_q == RESP);
  assign own_dm  = (owner_q == DATA);
  assign rsp     = in_resp & mem_rvalid;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign tmo   = in_resp & ~mem_rvalid & (cnt_q == 8'(TIMEOUT));
  assign cnt_d = (in_resp && state_d == RESP) ? cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo = (TIMEOUT < 0);
`endif

  assign timeout_err = tmo;

  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_be    = in_req ? be_q : '0;
  assign mem_addr  = in_req ? addr_q : '0;
  assign mem_wdata = in_req ? wdata_q : '0;

  assign if_gnt    = in_req & mem_ack & ~own_dm;
  assign dm_gnt    = in_req & mem_ack & own_dm;
  assign if_rvalid = rsp & ~own_dm & ~(fpend_q | flush);
  assign dm_rvalid = rsp & own_dm;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

  assign arb_eqmem = (state_q != IDLE) & own_dm;
  // completion cycle releases the pipeline
  assign stall_mem = (dm_req | arb_eqmem) & ~dm_rvalid;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          state_d = REQ;
          owner_d = sel_owner;
          if (sel_owner == DATA) begin
            we_d    = dm_we;
            be_d    = dm_be;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
          end else begin
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = if_addr;
            wdata_d = '0;
          end
        end
      end
      (state_q == REQ): begin
        if (mem_ack) state_d = RESP;
      end
      (state_q == RESP): begin
        if (mem_rvalid | tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (if_gnt)
      streak_d = '0;
    else if (dm_gnt & if_req & (streak_q != SW'(STARVE_MAX)))
      streak_d = streak_q + SW'(1);
  end

  always_comb begin
    fpend_d = fpend_q;
    if (state_d == IDLE)
      fpend_d = 1'b0;
    else if (flush & ~own_dm & (state_q != IDLE))
      fpend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      owner_q  <= FETCH;
      streak_q <= '0;
      fpend_q  <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      fpend_q  <= fpend_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule
